// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST fail logger slice.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encoding, log entry width helper, status bit positions.
package bist_pkg;

    // FSM encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOGGING  = 2'b01,
        ST_COMPLETE = 2'b10
    } bist_state_t;

    // Bit positions of pass/fail status in the top-level uo_out packing.
    localparam int STATUS_PASS_BIT = 0;
    localparam int STATUS_FAIL_BIT = 1;

    // A log entry is {address, syndrome}.
    function automatic int log_entry_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/bist_fail_logger_if.sv
// Compare stream from the BIST engine plus the valid/ready log read port.
// Latency: n/a (signal bundle only).
// Backpressure: compare stream has none; read port is valid/ready.
// Modports: master = BIST engine / tester side, slave = fail logger.
interface bist_fail_logger_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  cmp_valid;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [DATA_WIDTH-1:0] cmp_act;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_syndrome;

    modport master (
        output cmp_valid, cmp_addr, cmp_exp, cmp_act, rd_ready,
        input  rd_valid, rd_addr, rd_syndrome
    );

    modport slave (
        input  cmp_valid, cmp_addr, cmp_exp, cmp_act, rd_ready,
        output rd_valid, rd_addr, rd_syndrome
    );
endinterface

// File: rtl/bist_log_fifo.sv
// Small synchronous FIFO holding failure log entries.
// Latency: push visible at dout one cycle later; dout is combinational from head.
// Backpressure: push ignored when full unless popping same cycle; clr wins over push/pop.
// Ports: clk, rst_n, push, pop, clr, din, dout (0 when empty), empty, full.
module bist_log_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full + pop frees the head slot this cycle, so the push may proceed.
    assign w_do_pop  = pop && !empty && !clr;
    assign w_do_push = push && (!full || w_do_pop) && !clr;

    assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bist_fail_logger.sv
// Logs the first LOG_DEPTH failing BIST compares and counts all failures.
// Latency: failing beat at cycle N -> rd_valid / fail_count update at N+1.
// Backpressure: compare stream never stalls; entries are dropped (overflow) when the log is full.
// Ports: clk, rst_n, bist_start, bist_done, bus (compare + read port), fail_count, overflow, state_o, pass.
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LOG_DEPTH  = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bist_start,
    input  logic                 bist_done,
    bist_fail_logger_if.slave    bus,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic                 overflow,
    output logic [1:0]           state_o,
    output logic                 pass
);
    localparam int                   EW      = log_entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    bist_state_t          r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    logic                 r_pass;

    logic                 w_fail;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic [EW-1:0]        w_din;
    logic [EW-1:0]        w_dout;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // bist_start masks everything else in its cycle, including compares.
    assign w_fail = (r_state == ST_LOGGING) && bus.cmp_valid &&
                    (bus.cmp_exp != bus.cmp_act) && !bist_start;
    assign w_pop  = !w_empty && bus.rd_ready;
    assign w_push = w_fail && (!w_full || w_pop);
    assign w_din  = {bus.cmp_addr, bus.cmp_exp ^ bus.cmp_act};

    assign w_cnt_nxt = (w_fail && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

    bist_log_fifo #(
        .WIDTH (EW),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .clr   (bist_start),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_pass  <= 1'b0;
        end else if (bist_start) begin
            r_state <= ST_LOGGING;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pass <= 1'b0;
                end
                ST_LOGGING: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_fail && w_full && !w_pop) r_ovf <= 1'b1;
                    // A beat arriving with bist_done still counts toward pass.
                    if (bist_done) begin
                        r_state <= ST_COMPLETE;
                        r_pass  <= (w_cnt_nxt == '0);
                    end
                end
                ST_COMPLETE: begin
                    r_pass <= (r_cnt == '0);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_valid    = !w_empty;
    assign bus.rd_addr     = w_dout[EW-1:DATA_WIDTH];
    assign bus.rd_syndrome = w_dout[DATA_WIDTH-1:0];
    assign fail_count      = r_cnt;
    assign overflow        = r_ovf;
    assign state_o         = r_state;
    assign pass            = r_pass;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Randomized plus directed bench for bist_fail_logger against a queue-based model.
// Latency: n/a.
// Backpressure: rd_ready driven directly by the stimulus.
module tb_bist_fail_logger;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bist_start;
    logic          bist_done;
    logic [CW-1:0] fail_count;
    logic          overflow;
    logic [1:0]    state_o;
    logic          pass;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: log as a queue of {addr, syndrome}; state as 0/1/2.
    logic [AW+DW-1:0] m_q[$];
    int               m_cnt;
    logic             m_ovf;
    int               m_state;
    logic             m_pass;

    bist_fail_logger_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bist_fail_logger #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOG_DEPTH  (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bist_start (bist_start),
        .bist_done  (bist_done),
        .bus        (bus.slave),
        .fail_count (fail_count),
        .overflow   (overflow),
        .state_o    (state_o),
        .pass       (pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_state = 0;
        m_pass  = 1'b0;
    endtask

    task automatic check_all();
        logic [AW+DW-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        chk("rd_valid",    32'(bus.rd_valid),    32'(m_q.size() > 0));
        chk("rd_addr",     32'(bus.rd_addr),     32'(head[AW+DW-1:DW]));
        chk("rd_syndrome", 32'(bus.rd_syndrome), 32'(head[DW-1:0]));
        chk("fail_count",  32'(fail_count),      32'(m_cnt));
        chk("overflow",    32'(overflow),        32'(m_ovf));
        chk("state",       32'(state_o),         32'(m_state));
        chk("pass",        32'(pass),            32'(m_pass));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic s, input logic d, input logic v,
                        input logic [AW-1:0] a, input logic [DW-1:0] e,
                        input logic [DW-1:0] ac, input logic rr);
        bit f;
        bist_start    = s;
        bist_done     = d;
        bus.cmp_valid = v;
        bus.cmp_addr  = a;
        bus.cmp_exp   = e;
        bus.cmp_act   = ac;
        bus.rd_ready  = rr;
        if (s) begin
            m_q.delete();
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_state = 1;
            m_pass  = 1'b0;
        end else begin
            if (rr && m_q.size() > 0) void'(m_q.pop_front());
            f = (m_state == 1) && v && (e != ac);
            if (f) begin
                if (m_cnt < CMAX) m_cnt++;
                if (m_q.size() < DEPTH) m_q.push_back({a, e ^ ac});
                else m_ovf = 1'b1;
            end
            if (m_state == 1 && d) m_state = 2;
            m_pass = (m_state == 2) && (m_cnt == 0);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    initial begin
        int pops;
        logic [DW-1:0] e;
        rst_n = 1'b0;
        bist_start = 1'b0;
        bist_done = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.cmp_addr = '0;
        bus.cmp_exp = '0;
        bus.cmp_act = '0;
        bus.rd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // 1: clean run
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'(i), 8'(i * 7), 8'(i * 7), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_state", 32'(state_o), 32'd2);

        // 2: two failures, read in order
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd3, 8'h05, 8'h07, 0);
        step(0, 0, 1, 4'd9, 8'h0A, 8'h00, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("t2_head0_addr", 32'(bus.rd_addr), 32'h3);
        chk("t2_head0_syn",  32'(bus.rd_syndrome), 32'h02);
        idle(1);
        chk("t2_head1_addr", 32'(bus.rd_addr), 32'h9);
        chk("t2_head1_syn",  32'(bus.rd_syndrome), 32'h0A);
        idle(1);
        chk("t2_count", 32'(fail_count), 32'd2);
        chk("t2_pass", 32'(pass), 32'd0);

        // 3: six failures without reading -> overflow
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 4'(i + 1), 8'h00, 8'(i + 1), 0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_count", 32'(fail_count), 32'd6);

        // 4: full + pop + failing beat, then drain and count entries
        step(0, 0, 1, 4'hE, 8'hF0, 8'h0F, 1);
        chk("t4_ovf", 32'(overflow), 32'd1);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rd_valid) pops++;
            idle(1);
        end
        chk("t4_occupancy", 32'(pops), 32'd4);

        // 5: start masks a failing beat; done beat is counted
        step(1, 0, 1, 4'h1, 8'h11, 8'h22, 0);
        chk("t5_start_mask", 32'(fail_count), 32'd0);
        step(0, 1, 1, 4'h2, 8'h33, 8'h44, 0);
        chk("t5_done_cnt", 32'(fail_count), 32'd1);
        chk("t5_state", 32'(state_o), 32'd2);

        // 6: reset mid-run, then saturation
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'h4, 8'h01, 8'h03, 0);
        step(0, 0, 1, 4'h5, 8'h01, 8'h05, 0);
        rst_n = 1'b0;
        bist_start = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.rd_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 4'(i), 8'h55, 8'hAA, 0);
        chk("t6_sat", 32'(fail_count), 32'(CMAX));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            e = 8'($urandom);
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7), 4'($urandom),
                 e, ($urandom_range(0, 1) == 0) ? e : (e ^ 8'($urandom_range(1, 255))),
                 ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
